// File: rtl/alu_rsp_decoder.sv
// Serial response decoder for the mtm_Alu output stream: deserializes 11-bit frames,
// reassembles normal/error packets, checks CRC3 and parity, and flags framing faults.
module alu_rsp_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sout,
    output logic        rsp_valid,
    output logic [31:0] rsp_c,
    output logic [3:0]  rsp_flags,
    output logic        rsp_crc_ok,
    output logic        rsp_err,
    output logic [5:0]  rsp_err_flags,
    output logic        rsp_parity_ok,
    output logic        frame_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TYPE,
        S_PAYLOAD,
        S_STOP,
        S_RECOVER
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic [2:0]  dcnt_q, dcnt_d;
    logic        type_q, type_d;
    logic [7:0]  pay_q, pay_d;
    logic [31:0] c_q, c_d;
    logic        valid_q, valid_d;
    logic [31:0] rspC_q, rspC_d;
    logic [3:0]  flags_q, flags_d;
    logic        crcOk_q, crcOk_d;
    logic        err_q, err_d;
    logic [5:0]  errFlags_q, errFlags_d;
    logic        parOk_q, parOk_d;
    logic        ferr_q, ferr_d;
    logic        busy_q, busy_d;
    logic        seqErr;
    logic [2:0]  crcCalc;

    // CRC3, x^3+x+1, serial over {C, 0, FLAGS} MSB first
    function automatic logic [2:0] crc3(input logic [31:0] c, input logic [3:0] f);
        logic [35:0] d;
        logic [2:0]  r;
        logic        fb;
        d = {c, 1'b0, f};
        r = 3'b000;
        for (int i = 35; i >= 0; i--) begin
            fb = d[i] ^ r[2];
            r  = {r[1], r[0] ^ fb, fb};
        end
        return r;
    endfunction

    assign crcCalc = crc3(c_q, pay_q[6:3]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bcnt_q     <= '0;
            dcnt_q     <= '0;
            type_q     <= 1'b0;
            pay_q      <= '0;
            c_q        <= '0;
            valid_q    <= 1'b0;
            rspC_q     <= '0;
            flags_q    <= '0;
            crcOk_q    <= 1'b0;
            err_q      <= 1'b0;
            errFlags_q <= '0;
            parOk_q    <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            dcnt_q     <= dcnt_d;
            type_q     <= type_d;
            pay_q      <= pay_d;
            c_q        <= c_d;
            valid_q    <= valid_d;
            rspC_q     <= rspC_d;
            flags_q    <= flags_d;
            crcOk_q    <= crcOk_d;
            err_q      <= err_d;
            errFlags_q <= errFlags_d;
            parOk_q    <= parOk_d;
            ferr_q     <= ferr_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        dcnt_d     = dcnt_q;
        type_d     = type_q;
        pay_d      = pay_q;
        c_d        = c_q;
        valid_d    = 1'b0;
        rspC_d     = rspC_q;
        flags_d    = flags_q;
        crcOk_d    = crcOk_q;
        err_d      = err_q;
        errFlags_d = errFlags_q;
        parOk_d    = parOk_q;
        ferr_d     = 1'b0;
        busy_d     = busy_q;
        seqErr     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!sout) begin
                    state_d = S_TYPE;
                    busy_d  = 1'b1;
                end
            end
            S_TYPE: begin
                type_d  = sout;
                bcnt_d  = 3'd0;
                state_d = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                pay_d  = {pay_q[6:0], sout};
                bcnt_d = bcnt_q + 3'd1;
                if (bcnt_q == 3'd7) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                state_d = S_IDLE;
                if (!sout) begin
                    // A broken stop bit means we may be mid-byte; wait for a high before re-arming
                    ferr_d  = 1'b1;
                    dcnt_d  = 3'd0;
                    busy_d  = 1'b0;
                    state_d = S_RECOVER;
                end else if (!type_q) begin
                    if (dcnt_q != 3'd4) begin
                        c_d    = {c_q[23:0], pay_q};
                        dcnt_d = dcnt_q + 3'd1;
                    end else begin
                        seqErr = 1'b1;
                    end
                end else if (!pay_q[7]) begin
                    if (dcnt_q == 3'd4) begin
                        valid_d    = 1'b1;
                        rspC_d     = c_q;
                        flags_d    = pay_q[6:3];
                        crcOk_d    = (crcCalc == pay_q[2:0]);
                        err_d      = 1'b0;
                        errFlags_d = '0;
                        parOk_d    = 1'b0;
                        dcnt_d     = 3'd0;
                        busy_d     = 1'b0;
                    end else begin
                        seqErr = 1'b1;
                    end
                end else if (dcnt_q == 3'd0) begin
                    valid_d    = 1'b1;
                    rspC_d     = '0;
                    flags_d    = '0;
                    crcOk_d    = 1'b0;
                    err_d      = 1'b1;
                    errFlags_d = pay_q[6:1];
                    parOk_d    = ~^pay_q;
                    busy_d     = 1'b0;
                end else begin
                    seqErr = 1'b1;
                end
            end
            S_RECOVER: begin
                if (sout) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (seqErr) begin
            ferr_d = 1'b1;
            dcnt_d = 3'd0;
            busy_d = 1'b0;
        end
    end

    assign rsp_valid     = valid_q;
    assign rsp_c         = rspC_q;
    assign rsp_flags     = flags_q;
    assign rsp_crc_ok    = crcOk_q;
    assign rsp_err       = err_q;
    assign rsp_err_flags = errFlags_q;
    assign rsp_parity_ok = parOk_q;
    assign frame_err     = ferr_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_alu_rsp_decoder.sv
// Scoreboard bench for alu_rsp_decoder: drives serial frames, queues expected
// responses and compares each rsp_valid against the queue head.
module tb_alu_rsp_decoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sout;
   logic        rsp_valid;
   logic [31:0] rsp_c;
   logic [3:0]  rsp_flags;
   logic        rsp_crc_ok;
   logic        rsp_err;
   logic [5:0]  rsp_err_flags;
   logic        rsp_parity_ok;
   logic        frame_err;
   logic        busy;

   typedef struct packed {
      logic [31:0] c;
      logic [3:0]  flags;
      logic        crcOk;
      logic        err;
      logic [5:0]  errFlags;
      logic        parityOk;
   } rsp_t;

   rsp_t expQ[$];
   rsp_t monRsp;
   int   validTimes[$];
   int   checkCount = 0;
   int   passCount = 0;
   int   cycle = 0;
   int   validSeen = 0;
   int   validExp = 0;
   int   frameErrSeen = 0;
   int   frameErrExp = 0;
   logic [31:0] lastC = '0;

   alu_rsp_decoder dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .sout          (sout),
      .rsp_valid     (rsp_valid),
      .rsp_c         (rsp_c),
      .rsp_flags     (rsp_flags),
      .rsp_crc_ok    (rsp_crc_ok),
      .rsp_err       (rsp_err),
      .rsp_err_flags (rsp_err_flags),
      .rsp_parity_ok (rsp_parity_ok),
      .frame_err     (frame_err),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // Counts one comparison and reports it if the observed value differs
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
   endtask

   // Reference CRC3 as polynomial long division of {C, 0, FLAGS}
   function automatic logic [2:0] modelCrc(input logic [31:0] c, input logic [3:0] f);
      logic [35:0] d;
      logic [2:0]  r;
      logic        top;
      d = {c, 1'b0, f};
      r = 3'b000;
      for (int i = 35; i >= 0; i--) begin
         top = r[2] ^ d[i];
         r = {r[1:0], 1'b0} ^ (top ? 3'b011 : 3'b000);
      end
      return r;
   endfunction

   // Monitor: every valid pulse pops the scoreboard; frame errors are tallied
   always @(negedge clk) begin
      cycle++;
      if (rsp_valid === 1'b1) begin
         validSeen++;
         validTimes.push_back(cycle);
         checkOutput("busyAtValid", {31'd0, busy}, 32'd0);
         if (expQ.size() == 0) begin
            checkOutput("unexpectedValid", 32'd1, 32'd0);
         end else begin
            monRsp = expQ.pop_front();
            checkOutput("rsp_c", rsp_c, monRsp.c);
            checkOutput("rsp_flags", {28'd0, rsp_flags}, {28'd0, monRsp.flags});
            checkOutput("rsp_crc_ok", {31'd0, rsp_crc_ok}, {31'd0, monRsp.crcOk});
            checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, monRsp.err});
            checkOutput("rsp_err_flags", {26'd0, rsp_err_flags}, {26'd0, monRsp.errFlags});
            checkOutput("rsp_parity_ok", {31'd0, rsp_parity_ok}, {31'd0, monRsp.parityOk});
         end
      end
      if (frame_err === 1'b1) frameErrSeen++;
   end

   // Sends one 11-bit frame, one bit per clock, changing sout on the falling edge
   task automatic applyStimulus(input logic isCtl, input logic [7:0] payload, input logic stopBit);
      logic [10:0] bits;
      bits = {1'b0, isCtl, payload, stopBit};
      for (int i = 10; i >= 0; i--) begin
         @(negedge clk);
         sout = bits[i];
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sout = 1'b1;
      end
   endtask

   task automatic sendNormal(input logic [31:0] c, input logic [7:0] ctl);
      rsp_t e;
      e.c        = c;
      e.flags    = ctl[6:3];
      e.crcOk    = (modelCrc(c, ctl[6:3]) == ctl[2:0]);
      e.err      = 1'b0;
      e.errFlags = 6'd0;
      e.parityOk = 1'b0;
      expQ.push_back(e);
      validExp++;
      lastC = c;
      applyStimulus(1'b0, c[31:24], 1'b1);
      applyStimulus(1'b0, c[23:16], 1'b1);
      applyStimulus(1'b0, c[15:8], 1'b1);
      applyStimulus(1'b0, c[7:0], 1'b1);
      applyStimulus(1'b1, ctl, 1'b1);
   endtask

   task automatic sendError(input logic [7:0] payload);
      rsp_t e;
      e.c        = 32'd0;
      e.flags    = 4'd0;
      e.crcOk    = 1'b0;
      e.err      = 1'b1;
      e.errFlags = payload[6:1];
      e.parityOk = ~^payload;
      expQ.push_back(e);
      validExp++;
      lastC = 32'd0;
      applyStimulus(1'b1, payload, 1'b1);
   endtask

   task automatic checkCounts(input string tag);
      checkOutput({tag, "_valids"}, validSeen, validExp);
      checkOutput({tag, "_frameErrs"}, frameErrSeen, frameErrExp);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_valid"}, {31'd0, rsp_valid}, 32'd0);
      checkOutput({tag, "_c"}, rsp_c, 32'd0);
      checkOutput({tag, "_flags"}, {28'd0, rsp_flags}, 32'd0);
      checkOutput({tag, "_crcOk"}, {31'd0, rsp_crc_ok}, 32'd0);
      checkOutput({tag, "_err"}, {31'd0, rsp_err}, 32'd0);
      checkOutput({tag, "_errFlags"}, {26'd0, rsp_err_flags}, 32'd0);
      checkOutput({tag, "_parityOk"}, {31'd0, rsp_parity_ok}, 32'd0);
      checkOutput({tag, "_frameErr"}, {31'd0, frame_err}, 32'd0);
      checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int t0;
      logic [31:0] rc;
      logic [3:0]  rf;
      rst_n = 1'b0;
      sout  = 1'b1;
      repeat (4) @(negedge clk);
      checkAllZero("reset");
      rst_n = 1'b1;
      idle(3);

      // ADD 0xFF+0xFF with correct CRC, plus a busy probe between frames
      applyStimulus(1'b0, 8'h00, 1'b1);
      idle(1);
      checkOutput("busyMidPacket", {31'd0, busy}, 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      applyStimulus(1'b0, 8'h01, 1'b1);
      applyStimulus(1'b0, 8'hFE, 1'b1);
      begin
         rsp_t e;
         e = '{c: 32'h000001FE, flags: 4'h0, crcOk: 1'b1, err: 1'b0, errFlags: 6'd0, parityOk: 1'b0};
         expQ.push_back(e);
         validExp++;
      end
      applyStimulus(1'b1, 8'h04, 1'b1);
      idle(3);
      sendNormal(32'h000001FE, 8'h05);
      idle(3);
      sendError(8'h93);
      idle(3);
      sendError(8'h92);
      idle(3);
      checkCounts("basic");

      for (int i = 0; i < 4; i++) begin
         rc = $urandom;
         rf = 4'($urandom_range(0, 15));
         if (i == 3) sendNormal(rc, {1'b0, rf, ~modelCrc(rc, rf)});
         else sendNormal(rc, {1'b0, rf, modelCrc(rc, rf)});
         idle(2);
      end
      idle(2);
      checkCounts("random");

      // Bad stop bit on the second DATA frame, line held low before re-arming
      applyStimulus(1'b0, 8'h00, 1'b1);
      applyStimulus(1'b0, 8'h11, 1'b0);
      frameErrExp++;
      repeat (4) @(negedge clk);
      idle(3);
      checkCounts("stopErr");
      checkOutput("holdAfterStopErr", rsp_c, lastC);
      sendNormal(32'hCAFE1234, {1'b0, 4'b1010, modelCrc(32'hCAFE1234, 4'b1010)});
      idle(3);
      checkCounts("afterStopErr");

      // Sequencing: CTL after two DATA, then five DATA frames
      applyStimulus(1'b0, 8'hAA, 1'b1);
      applyStimulus(1'b0, 8'hBB, 1'b1);
      applyStimulus(1'b1, 8'h04, 1'b1);
      frameErrExp++;
      idle(3);
      checkCounts("shortPacket");
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'(i), 1'b1);
      frameErrExp++;
      idle(3);
      checkCounts("fiveData");
      checkOutput("holdAfterSeqErr", rsp_c, lastC);

      // Back-to-back packets with no idle bits
      t0 = validTimes.size();
      sendNormal(32'h12345678, {1'b0, 4'b0001, modelCrc(32'h12345678, 4'b0001)});
      sendNormal(32'h80000000, {1'b0, 4'b1001, modelCrc(32'h80000000, 4'b1001)});
      idle(3);
      checkCounts("backToBack");
      if (validTimes.size() >= t0 + 2)
         checkOutput("b2bSpacing", validTimes[t0 + 1] - validTimes[t0], 32'd55);
      else
         checkOutput("b2bPulses", validTimes.size() - t0, 32'd2);

      // Reset during the third DATA frame
      applyStimulus(1'b0, 8'h01, 1'b1);
      applyStimulus(1'b0, 8'h02, 1'b1);
      @(negedge clk); sout = 1'b0;
      @(negedge clk); sout = 1'b0;
      repeat (3) begin @(negedge clk); sout = 1'b1; end
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkAllZero("midReset");
      rst_n = 1'b1;
      idle(3);
      checkCounts("afterReset");
      sendNormal(32'h0F0F0F0F, {1'b0, 4'b0100, modelCrc(32'h0F0F0F0F, 4'b0100)});
      idle(3);
      checkCounts("final");
      checkOutput("queueEmpty", expQ.size(), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
